// File: rtl/dbus_pkg.sv
// ---------------------------------------------------------------------------
// dbus_pkg
// Shared definitions for the two-master data bus arbiter.
//   - dbus_state_e : arbiter FSM state encoding (IDLE, ACCESS, RESP)
//   - DBUS_IO_BASE : default first byte address mapped onto the GPIO block
//   - M_CPU/M_DBG  : master identifiers used for grant_id and last_grant
//   - isIoAddr     : address decode helper (unsigned compare against IO base)
// ---------------------------------------------------------------------------
package dbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } dbus_state_e;

    localparam logic [31:0] DBUS_IO_BASE = 32'h0300_0000;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DBG = 1'b1;

    // Everything at or above the IO base belongs to GPIO, so every address
    // decodes to exactly one slave and no error response is ever needed.
    function automatic logic isIoAddr(input logic [31:0] addr,
                                      input logic [31:0] ioBase);
        return (addr >= ioBase);
    endfunction

endpackage

// File: rtl/dbus_rr_pick.sv
// ---------------------------------------------------------------------------
// dbus_rr_pick
// Chooses which master wins the bus when the arbiter is idle.
// Ports:
//   req_i         [1:0] in  request lines, bit 0 = CPU, bit 1 = loader/debug
//   last_grant_i        in  owner of the most recently completed transaction
//   grant_valid_o       out at least one master is requesting
//   grant_id_o          out winning master id
// Configuration:
//   ARB_M1_PRIO_EN defined   -> master 1 wins every conflict (fixed priority)
//   ARB_M1_PRIO_EN undefined -> conflicts alternate (round-robin)
// ---------------------------------------------------------------------------
module dbus_rr_pick
    import dbus_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       grant_valid_o,
    output logic       grant_id_o
);

`ifdef ARB_M1_PRIO_EN
    // Fixed priority does not look at history; the input is kept on the
    // port so the arbiter is identical in both builds.
    logic unusedLastGrant;
    assign unusedLastGrant = last_grant_i;
`endif

    // A lone requester always wins. On a conflict the round-robin build
    // hands the bus to whoever did not have it last time, while the
    // priority build always favours the loader/debug port.
    always_comb begin
        grant_valid_o = |req_i;
        grant_id_o    = M_CPU;
        if (req_i == 2'b11) begin
`ifdef ARB_M1_PRIO_EN
            grant_id_o = M_DBG;
`else
            grant_id_o = ~last_grant_i;
`endif
        end else if (req_i[1]) begin
            grant_id_o = M_DBG;
        end
    end

endmodule

// File: rtl/dbus_arbiter.sv
// ---------------------------------------------------------------------------
// dbus_arbiter
// Two-master arbiter and address decoder for the shared data bus. Each
// transaction runs IDLE -> ACCESS -> RESP and then returns to IDLE, so a
// request is acknowledged two cycles after it is sampled and at least one
// idle cycle separates transactions.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   m0_req/we/addr/wdata  in        CPU load/store port request
//   m0_rdata/ack          out       CPU read data and one-cycle ack
//   m1_*                            same for the loader/debug port
//   mem_we/addr/wdata     out       data memory access (addr < IO_BASE)
//   mem_rdata             in        data memory read data
//   io_we/adr/wdata       out       GPIO register access (addr >= IO_BASE)
//   io_rdata              in        GPIO read data
//   bus_busy              out       high while in ACCESS or RESP
//   grant_id              out       owner of current/most recent transaction
// Parameters: IO_BASE (GPIO base byte address), IO_ADR_W (GPIO index width)
// Configuration: ARB_M1_PRIO_EN selects fixed master-1 priority on conflicts
// (handled inside dbus_rr_pick).
// ---------------------------------------------------------------------------
module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter logic [31:0] IO_BASE  = DBUS_IO_BASE,
    parameter int          IO_ADR_W = 5
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [31:0]         m0_addr,
    input  logic [31:0]         m0_wdata,
    output logic [31:0]         m0_rdata,
    output logic                m0_ack,

    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [31:0]         m1_addr,
    input  logic [31:0]         m1_wdata,
    output logic [31:0]         m1_rdata,
    output logic                m1_ack,

    output logic                mem_we,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wdata,
    input  logic [31:0]         mem_rdata,

    output logic                io_we,
    output logic [IO_ADR_W-1:0] io_adr,
    output logic [31:0]         io_wdata,
    input  logic [31:0]         io_rdata,

    output logic                bus_busy,
    output logic                grant_id
);

    dbus_state_e state_q, state_d;

    logic        grantId_q;
    logic        lastGrant_q;
    logic        latWe_q;
    logic [31:0] latAddr_q;
    logic [31:0] latWdata_q;
    logic [31:0] m0Rdata_q;
    logic [31:0] m1Rdata_q;

    logic        grantValid;
    logic        pickId;
    logic        accessIsIo;
    logic [31:0] readValue;

    dbus_rr_pick uPick (
        .req_i         ({m1_req, m0_req}),
        .last_grant_i  (lastGrant_q),
        .grant_valid_o (grantValid),
        .grant_id_o    (pickId)
    );

    // Decode of the latched address and the value to hand back to the
    // master. Writes return zero so the master's rdata is well defined.
    assign accessIsIo = isIoAddr(latAddr_q, IO_BASE);
    assign readValue  = latWe_q    ? 32'd0 :
                        accessIsIo ? io_rdata : mem_rdata;

    // State register. Reset drops straight back to IDLE, which abandons any
    // transaction in flight without acknowledging it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Requests are only looked at in IDLE, which is what
    // guarantees the idle gap between transactions: a request raised during
    // ACCESS or RESP simply waits.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (grantValid) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Transaction datapath. The winner's command is captured at grant time
    // so the slave sees a stable access even though the master keeps
    // driving its own signals. Read data is captured into the owning
    // master's register at the end of ACCESS so it is valid alongside the
    // ack and keeps its value afterwards. last_grant starts at the debug
    // port so the CPU wins the first conflict after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            grantId_q   <= M_CPU;
            lastGrant_q <= M_DBG;
            latWe_q     <= 1'b0;
            latAddr_q   <= 32'd0;
            latWdata_q  <= 32'd0;
            m0Rdata_q   <= 32'd0;
            m1Rdata_q   <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grantValid) begin
                        grantId_q <= pickId;
                        if (pickId == M_DBG) begin
                            latWe_q    <= m1_we;
                            latAddr_q  <= m1_addr;
                            latWdata_q <= m1_wdata;
                        end else begin
                            latWe_q    <= m0_we;
                            latAddr_q  <= m0_addr;
                            latWdata_q <= m0_wdata;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (grantId_q == M_DBG) begin
                        m1Rdata_q <= readValue;
                    end else begin
                        m0Rdata_q <= readValue;
                    end
                end
                ST_RESP: begin
                    lastGrant_q <= grantId_q;
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode. Slave strobes, addresses and data are only driven
    // during ACCESS and only towards the selected slave; everything else
    // sits at zero so at most one strobe is ever high. Acks are a single
    // RESP-cycle pulse to the owner of the transaction.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        io_we     = 1'b0;
        io_adr    = '0;
        io_wdata  = 32'd0;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        m0_rdata  = m0Rdata_q;
        m1_rdata  = m1Rdata_q;
        bus_busy  = (state_q != ST_IDLE);
        grant_id  = grantId_q;
        case (state_q)
            ST_ACCESS: begin
                if (accessIsIo) begin
                    io_we    = latWe_q;
                    io_adr   = latAddr_q[IO_ADR_W-1:0];
                    io_wdata = latWdata_q;
                end else begin
                    mem_we    = latWe_q;
                    mem_addr  = latAddr_q;
                    mem_wdata = latWdata_q;
                end
            end
            ST_RESP: begin
                m0_ack = (grantId_q == M_CPU);
                m1_ack = (grantId_q == M_DBG);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dbus_arbiter
// Directed bench for dbus_arbiter. Inputs are driven and outputs sampled on
// the falling clock edge. The slaves are tiny combinational models:
//   mem_rdata = mem_addr ^ 32'h5A5A0000
//   io_rdata  = 32'hA1 + io_adr   (index 4 reads back 32'hA5)
// Build with ARB_M1_PRIO_EN defined to check the fixed-priority variant.
// ---------------------------------------------------------------------------
module tb_dbus_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack;
    logic        mem_we, io_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [4:0]  io_adr;
    logic [31:0] io_wdata, io_rdata;
    logic        bus_busy, grant_id;

    int testsRun    = 0;
    int testsFailed = 0;

`ifdef ARB_M1_PRIO_EN
    localparam bit Prio = 1'b1;
`else
    localparam bit Prio = 1'b0;
`endif

    dbus_arbiter #(.IO_BASE(32'h0300_0000), .IO_ADR_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_rdata  (m0_rdata),
        .m0_ack    (m0_ack),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_rdata  (m1_rdata),
        .m1_ack    (m1_ack),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .io_we     (io_we),
        .io_adr    (io_adr),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata),
        .bus_busy  (bus_busy),
        .grant_id  (grant_id)
    );

    assign mem_rdata = mem_addr ^ 32'h5A5A_0000;
    assign io_rdata  = 32'h0000_00A1 + {27'd0, io_adr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input int master, input logic req, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        if (master == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    task automatic resetDut();
        reset = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0);
        applyStimulus(1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0);
        applyStimulus(1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        testsRun++; if (bus_busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_busy: got %b expected 0", bus_busy); end
        testsRun++; if (grant_id !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_grant: got %b expected 0", grant_id); end
        testsRun++; if ({m0_ack, m1_ack, mem_we, io_we} !== 4'b0000) begin testsFailed++; $display("[TB] FAIL rst_strobes: got %b expected 0000", {m0_ack, m1_ack, mem_we, io_we}); end
        testsRun++; if ({mem_addr, mem_wdata, io_wdata} !== 96'd0 || io_adr !== 5'd0) begin testsFailed++; $display("[TB] FAIL rst_slave_bus: got %h/%h/%h/%h expected zeros", mem_addr, mem_wdata, io_wdata, io_adr); end
        testsRun++; if ({m0_rdata, m1_rdata} !== 64'd0) begin testsFailed++; $display("[TB] FAIL rst_rdata: got %h/%h expected 0/0", m0_rdata, m1_rdata); end
        reset = 1'b0;
        @(negedge clk);
        testsRun++; if (bus_busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_idle_busy: got %b expected 0", bus_busy); end
    endtask

    task automatic test_mem_write();
        applyStimulus(0, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        @(negedge clk);
        testsRun++; if (mem_we !== 1'b1) begin testsFailed++; $display("[TB] FAIL wr_mem_we: got %b expected 1", mem_we); end
        testsRun++; if (mem_addr !== 32'h10) begin testsFailed++; $display("[TB] FAIL wr_mem_addr: got %h expected 00000010", mem_addr); end
        testsRun++; if (mem_wdata !== 32'hDEAD_BEEF) begin testsFailed++; $display("[TB] FAIL wr_mem_wdata: got %h expected deadbeef", mem_wdata); end
        testsRun++; if (io_we !== 1'b0) begin testsFailed++; $display("[TB] FAIL wr_io_we: got %b expected 0", io_we); end
        testsRun++; if (bus_busy !== 1'b1 || grant_id !== 1'b0) begin testsFailed++; $display("[TB] FAIL wr_busy_grant: got %b/%b expected 1/0", bus_busy, grant_id); end
        testsRun++; if (m0_ack !== 1'b0) begin testsFailed++; $display("[TB] FAIL wr_early_ack: got %b expected 0", m0_ack); end
        @(negedge clk);
        testsRun++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin testsFailed++; $display("[TB] FAIL wr_ack: got %b/%b expected 1/0", m0_ack, m1_ack); end
        testsRun++; if (mem_we !== 1'b0 || mem_addr !== 32'd0) begin testsFailed++; $display("[TB] FAIL wr_resp_mem: got %b/%h expected 0/00000000", mem_we, mem_addr); end
        testsRun++; if (m0_rdata !== 32'd0) begin testsFailed++; $display("[TB] FAIL wr_rdata: got %h expected 00000000", m0_rdata); end
        applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        testsRun++; if (bus_busy !== 1'b0 || m0_ack !== 1'b0) begin testsFailed++; $display("[TB] FAIL wr_idle: got %b/%b expected 0/0", bus_busy, m0_ack); end
    endtask

    task automatic test_mem_read();
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
        @(negedge clk);
        testsRun++; if (mem_we !== 1'b0 || mem_addr !== 32'h100) begin testsFailed++; $display("[TB] FAIL rd_mem_access: got %b/%h expected 0/00000100", mem_we, mem_addr); end
        @(negedge clk);
        testsRun++; if (m0_ack !== 1'b1 || m0_rdata !== 32'h5A5A_0100) begin testsFailed++; $display("[TB] FAIL rd_mem_data: got %b/%h expected 1/5a5a0100", m0_ack, m0_rdata); end
        applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        testsRun++; if (m0_rdata !== 32'h5A5A_0100) begin testsFailed++; $display("[TB] FAIL rd_mem_hold: got %h expected 5a5a0100", m0_rdata); end
    endtask

    task automatic test_io_read();
        applyStimulus(1, 1'b1, 1'b0, 32'h0300_0004, 32'h0);
        @(negedge clk);
        testsRun++; if (io_adr !== 5'h04 || io_we !== 1'b0) begin testsFailed++; $display("[TB] FAIL io_access: got %h/%b expected 04/0", io_adr, io_we); end
        testsRun++; if (mem_we !== 1'b0 || mem_addr !== 32'd0) begin testsFailed++; $display("[TB] FAIL io_mem_quiet: got %b/%h expected 0/00000000", mem_we, mem_addr); end
        testsRun++; if (grant_id !== 1'b1) begin testsFailed++; $display("[TB] FAIL io_grant: got %b expected 1", grant_id); end
        @(negedge clk);
        testsRun++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin testsFailed++; $display("[TB] FAIL io_ack: got %b/%b expected 1/0", m1_ack, m0_ack); end
        testsRun++; if (m1_rdata !== 32'h0000_00A5) begin testsFailed++; $display("[TB] FAIL io_rdata: got %h expected 000000a5", m1_rdata); end
        testsRun++; if (m0_rdata !== 32'h5A5A_0100) begin testsFailed++; $display("[TB] FAIL io_m0_hold: got %h expected 5a5a0100", m0_rdata); end
        applyStimulus(1, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        testsRun++; if (m1_rdata !== 32'h0000_00A5 || grant_id !== 1'b1) begin testsFailed++; $display("[TB] FAIL io_idle_hold: got %h/%b expected 000000a5/1", m1_rdata, grant_id); end
    endtask

    task automatic test_conflict();
        logic firstId;
        firstId = Prio ? 1'b1 : 1'b0;
        resetDut();
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 32'h0300_0008, 32'h0);
        @(negedge clk);
        testsRun++; if (grant_id !== firstId) begin testsFailed++; $display("[TB] FAIL cf_grant1: got %b expected %b", grant_id, firstId); end
        @(negedge clk);
        testsRun++; if (m0_ack !== ~firstId || m1_ack !== firstId) begin testsFailed++; $display("[TB] FAIL cf_ack1: got %b/%b expected %b/%b", m0_ack, m1_ack, ~firstId, firstId); end
        applyStimulus(int'(firstId), 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        testsRun++; if ({m0_ack, m1_ack, bus_busy} !== 3'b000) begin testsFailed++; $display("[TB] FAIL cf_gap: got %b expected 000", {m0_ack, m1_ack, bus_busy}); end
        @(negedge clk);
        testsRun++; if (grant_id !== ~firstId || bus_busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL cf_grant2: got %b/%b expected %b/1", grant_id, bus_busy, ~firstId); end
        @(negedge clk);
        testsRun++; if (m0_ack !== firstId || m1_ack !== ~firstId) begin testsFailed++; $display("[TB] FAIL cf_ack2: got %b/%b expected %b/%b", m0_ack, m1_ack, firstId, ~firstId); end
        applyStimulus(int'(~firstId), 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic expId;
        resetDut();
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 32'h0300_0001, 32'h0);
        for (int i = 0; i < 4; i++) begin
            expId = Prio ? 1'b1 : i[0];
            @(negedge clk);
            testsRun++; if (grant_id !== expId) begin testsFailed++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", i, grant_id, expId); end
            @(negedge clk);
            testsRun++; if (m0_ack !== ~expId) begin testsFailed++; $display("[TB] FAIL rr_m0ack%0d: got %b expected %b", i, m0_ack, ~expId); end
            testsRun++; if (m1_ack !== expId) begin testsFailed++; $display("[TB] FAIL rr_m1ack%0d: got %b expected %b", i, m1_ack, expId); end
            if (i == 3) begin
                applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0);
                applyStimulus(1, 1'b0, 1'b0, 32'd0, 32'd0);
            end
            @(negedge clk);
            testsRun++; if (bus_busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL rr_gap%0d: got %b expected 0", i, bus_busy); end
        end
    endtask

    logic [31:0] bAddr  [3] = '{32'h02FF_FFFC, 32'h0300_0000, 32'hFFFF_FFFF};
    logic        bIsIo  [3] = '{1'b0, 1'b1, 1'b1};
    logic [4:0]  bIoAdr [3] = '{5'h00, 5'h00, 5'h1F};

    task automatic test_boundary();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1'b1, 1'b1, bAddr[i], 32'h1234_5678);
            @(negedge clk);
            testsRun++; if (mem_we !== ~bIsIo[i] || io_we !== bIsIo[i]) begin testsFailed++; $display("[TB] FAIL bd_strobe%0d: got mem_we=%b io_we=%b expected %b/%b", i, mem_we, io_we, ~bIsIo[i], bIsIo[i]); end
            testsRun++; if (mem_addr !== (bIsIo[i] ? 32'd0 : bAddr[i])) begin testsFailed++; $display("[TB] FAIL bd_mem_addr%0d: got %h expected %h", i, mem_addr, bIsIo[i] ? 32'd0 : bAddr[i]); end
            testsRun++; if (io_adr !== bIoAdr[i]) begin testsFailed++; $display("[TB] FAIL bd_io_adr%0d: got %h expected %h", i, io_adr, bIoAdr[i]); end
            testsRun++; if (io_wdata !== (bIsIo[i] ? 32'h1234_5678 : 32'd0)) begin testsFailed++; $display("[TB] FAIL bd_io_wdata%0d: got %h expected %h", i, io_wdata, bIsIo[i] ? 32'h1234_5678 : 32'd0); end
            @(negedge clk);
            testsRun++; if (m0_ack !== 1'b1 || mem_we !== 1'b0 || io_we !== 1'b0) begin testsFailed++; $display("[TB] FAIL bd_resp%0d: got ack=%b mem_we=%b io_we=%b expected 1/0/0", i, m0_ack, mem_we, io_we); end
            applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_access();
        applyStimulus(0, 1'b1, 1'b1, 32'h0000_0020, 32'h0000_1111);
        @(negedge clk);
        testsRun++; if (mem_we !== 1'b1) begin testsFailed++; $display("[TB] FAIL ra_access: got %b expected 1", mem_we); end
        reset = 1'b1;
        @(negedge clk);
        testsRun++; if (mem_we !== 1'b0 || m0_ack !== 1'b0) begin testsFailed++; $display("[TB] FAIL ra_abort: got mem_we=%b ack=%b expected 0/0", mem_we, m0_ack); end
        testsRun++; if (bus_busy !== 1'b0 || grant_id !== 1'b0) begin testsFailed++; $display("[TB] FAIL ra_idle: got %b/%b expected 0/0", bus_busy, grant_id); end
        testsRun++; if (m1_rdata !== 32'd0) begin testsFailed++; $display("[TB] FAIL ra_rdata_clr: got %h expected 00000000", m1_rdata); end
        reset = 1'b0;
        @(negedge clk);
        testsRun++; if (mem_we !== 1'b1 || mem_addr !== 32'h20) begin testsFailed++; $display("[TB] FAIL ra_restart: got %b/%h expected 1/00000020", mem_we, mem_addr); end
        @(negedge clk);
        testsRun++; if (m0_ack !== 1'b1) begin testsFailed++; $display("[TB] FAIL ra_ack: got %b expected 1", m0_ack); end
        applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mem_write();
        test_mem_read();
        test_io_read();
        test_boundary();
        test_reset_mid_access();
        test_conflict();
        test_round_robin();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
